// File: rtl/sd_spi_init_seq_if.sv
// Handshake bundle between the SD init sequencer (master) and the SD command
// controller (slave): command launch, command fields and R1/R3/R7 responses.
interface sd_spi_init_seq_if;
  logic        ctrl_available;
  logic        ctrl_valid_status;
  logic [6:0]  ctrl_status;
  logic [31:0] ctrl_resp_ext;
  logic        ctrl_start;
  logic [5:0]  cmd;
  logic [31:0] cmd_arg;

  modport master (
    input  ctrl_available, ctrl_valid_status, ctrl_status, ctrl_resp_ext,
    output ctrl_start, cmd, cmd_arg
  );

  modport slave (
    output ctrl_available, ctrl_valid_status, ctrl_status, ctrl_resp_ext,
    input  ctrl_start, cmd, cmd_arg
  );
endinterface

// File: rtl/sd_spi_init_seq.sv
// SPI-mode SD card init sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop,
// CMD58; detects v1 / v2-SC / v2-HC cards and reports a coded error on failure.
module sd_spi_init_seq #(
  parameter int unsigned       DUMMY_CLKS   = 80,
  parameter int unsigned       DIV_W        = 8,
  parameter logic [DIV_W-1:0]  SLOW_DIV     = DIV_W'(8'hFF),
  parameter logic [DIV_W-1:0]  FAST_DIV     = DIV_W'(8'h00),
  parameter int unsigned       CMD0_RETRY   = 8,
  parameter int unsigned       ACMD41_RETRY = 1000,
  parameter int unsigned       RETRY_W      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_req,
  input  logic                 sclk_fall,
  sd_spi_init_seq_if.master    ctrl,
  output logic                 cs,
  output logic                 en_clk,
  output logic [DIV_W-1:0]     div_clk,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           err_code,
  output logic                 sdhc
);

  // Each wait state directly follows its command state in the encoding.
  typedef enum logic [3:0] {
    S_PWRUP    = 4'd0,
    S_CMD0     = 4'd1,
    S_CMD0_W   = 4'd2,
    S_CMD8     = 4'd3,
    S_CMD8_W   = 4'd4,
    S_CMD55    = 4'd5,
    S_CMD55_W  = 4'd6,
    S_ACMD41   = 4'd7,
    S_ACMD41_W = 4'd8,
    S_CMD58    = 4'd9,
    S_CMD58_W  = 4'd10,
    S_DONE     = 4'd11,
    S_ERROR    = 4'd12
  } state_e;

  localparam logic [7:0]         DUMMY_LIM  = 8'(DUMMY_CLKS);
  localparam logic [RETRY_W-1:0] CMD0_LIM   = RETRY_W'(CMD0_RETRY);
  localparam logic [RETRY_W-1:0] ACMD41_LIM = RETRY_W'(ACMD41_RETRY);

  state_e             state_q, state_d;
  logic [7:0]         dummy_q, dummy_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               v2_q, v2_d;
  logic               cs_q, cs_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               sdhc_q, sdhc_d;
  logic               start_q, start_d;
  logic [5:0]         cmd_q, cmd_d;
  logic [31:0]        arg_q, arg_d;

  logic unused_ext;
  assign unused_ext = ^{ctrl.ctrl_resp_ext[31], ctrl.ctrl_resp_ext[29:12]};

  assign retry_inc = retry_q + RETRY_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PWRUP;
      dummy_q    <= '0;
      retry_q    <= '0;
      v2_q       <= 1'b0;
      cs_q       <= 1'b1;
      div_q      <= SLOW_DIV;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
      sdhc_q     <= 1'b0;
      start_q    <= 1'b0;
      cmd_q      <= '0;
      arg_q      <= '0;
    end else begin
      state_q    <= state_d;
      dummy_q    <= dummy_d;
      retry_q    <= retry_d;
      v2_q       <= v2_d;
      cs_q       <= cs_d;
      div_q      <= div_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      sdhc_q     <= sdhc_d;
      start_q    <= start_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dummy_d    = dummy_q;
    retry_d    = retry_q;
    v2_d       = v2_q;
    cs_d       = cs_q;
    div_d      = div_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    sdhc_d     = sdhc_q;
    start_d    = 1'b0;
    cmd_d      = cmd_q;
    arg_d      = arg_q;

    unique case (state_q)
      S_PWRUP: begin
        if (sclk_fall) begin
          dummy_d = dummy_q + 8'd1;
          if (dummy_d == DUMMY_LIM) begin
            state_d = S_CMD0;
            cs_d    = 1'b0;
          end
        end
      end
      S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58: begin
        if (ctrl.ctrl_available) begin
          start_d = 1'b1;
          state_d = state_e'(state_q + 4'd1);
        end
      end
      S_CMD0_W: begin
        if (ctrl.ctrl_valid_status) begin
          if (ctrl.ctrl_status == 7'h01) begin
            state_d = S_CMD8;
          end else begin
            retry_d = retry_inc;
            if (retry_inc == CMD0_LIM) begin
              state_d    = S_ERROR;
              err_code_d = 3'd1;
            end else begin
              state_d = S_CMD0;
            end
          end
        end
      end
      S_CMD8_W: begin
        if (ctrl.ctrl_valid_status) begin
          retry_d = '0;
          if (ctrl.ctrl_status[2]) begin
            v2_d    = 1'b0;
            state_d = S_CMD55;
          end else if (ctrl.ctrl_status == 7'h01 && ctrl.ctrl_resp_ext[11:0] == 12'h1AA) begin
            v2_d    = 1'b1;
            state_d = S_CMD55;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 3'd2;
          end
        end
      end
      S_CMD55_W: begin
        if (ctrl.ctrl_valid_status) begin
          if (ctrl.ctrl_status[6:1] == 6'd0) begin
            state_d = S_ACMD41;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 3'd3;
          end
        end
      end
      S_ACMD41_W: begin
        if (ctrl.ctrl_valid_status) begin
          if (ctrl.ctrl_status == 7'h00) begin
            if (v2_q) begin
              state_d = S_CMD58;
            end else begin
              state_d = S_DONE;
              sdhc_d  = 1'b0;
            end
          end else if (ctrl.ctrl_status == 7'h01) begin
            retry_d = retry_inc;
            if (retry_inc == ACMD41_LIM) begin
              state_d    = S_ERROR;
              err_code_d = 3'd4;
            end else begin
              state_d = S_CMD55;
            end
          end else begin
            state_d    = S_ERROR;
            err_code_d = 3'd3;
          end
        end
      end
      S_CMD58_W: begin
        if (ctrl.ctrl_valid_status) begin
          if (ctrl.ctrl_status == 7'h00) begin
            sdhc_d  = ctrl.ctrl_resp_ext[30];
            state_d = S_DONE;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 3'd5;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (init_req) begin
          state_d    = S_PWRUP;
          dummy_d    = '0;
          retry_d    = '0;
          v2_d       = 1'b0;
          cs_d       = 1'b1;
          div_d      = SLOW_DIV;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = '0;
          sdhc_d     = 1'b0;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // Terminal-state outputs are applied once, on entry.
    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d = 1'b1;
      cs_d   = 1'b0;
      div_d  = FAST_DIV;
    end
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      error_d = 1'b1;
      cs_d    = 1'b1;
      div_d   = SLOW_DIV;
    end

    // Command fields are loaded on entry and held through the wait state.
    unique case (state_d)
      S_CMD0:   begin cmd_d = 6'd0;  arg_d = 32'h0000_0000; end
      S_CMD8:   begin cmd_d = 6'd8;  arg_d = 32'h0000_01AA; end
      S_CMD55:  begin cmd_d = 6'd55; arg_d = 32'h0000_0000; end
      S_ACMD41: begin cmd_d = 6'd41; arg_d = v2_q ? 32'h4000_0000 : 32'h0000_0000; end
      S_CMD58:  begin cmd_d = 6'd58; arg_d = 32'h0000_0000; end
      default: ;
    endcase
  end

  assign ctrl.ctrl_start = start_q;
  assign ctrl.cmd        = cmd_q;
  assign ctrl.cmd_arg    = arg_q;
  assign cs              = cs_q;
  assign en_clk          = 1'b1;
  assign div_clk         = div_q;
  assign done            = done_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign sdhc            = sdhc_q;

endmodule

// File: tb/tb_sd_spi_init_seq.sv
// Bench for sd_spi_init_seq: a table of card-response scenarios driven through a
// small command-controller responder, plus hand sequences for reset and stalls.
module tb_sd_spi_init_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_req;
  logic       sclk_fall;
  logic       cs;
  logic       en_clk;
  logic [7:0] div_clk;
  logic       done;
  logic       error;
  logic [2:0] err_code;
  logic       sdhc;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sd_spi_init_seq_if bus ();

  sd_spi_init_seq #(
    .DUMMY_CLKS  (80),
    .DIV_W       (8),
    .SLOW_DIV    (8'hFF),
    .FAST_DIV    (8'h00),
    .CMD0_RETRY  (8),
    .ACMD41_RETRY(4),
    .RETRY_W     (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .sclk_fall(sclk_fall),
    .ctrl     (bus),
    .cs       (cs),
    .en_clk   (en_clk),
    .div_clk  (div_clk),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .sdhc     (sdhc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  r0;
    logic [6:0]  r8;
    logic [31:0] e8;
    logic [6:0]  r55;
    int unsigned busy;   // ACMD41 launches answered 0x01 before r41
    logic [6:0]  r41;
    logic [6:0]  r58;
    logic [31:0] e58;
    bit          stall;
    bit          x_done;
    bit          x_err;
    logic [2:0]  x_code;
    bit          x_sdhc;
    int unsigned n0, n8, n55, n41, n58;
    logic [31:0] arg41;  // all-ones when no ACMD41 is expected
  } vec_t;

  vec_t vt[9];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic respond(input logic [6:0] st, input logic [31:0] ext);
    tick();
    chk("start_one_cycle", {31'd0, bus.ctrl_start}, 32'd0);
    bus.ctrl_valid_status = 1'b1;
    bus.ctrl_status       = st;
    bus.ctrl_resp_ext     = ext;
    tick();
    bus.ctrl_valid_status = 1'b0;
    bus.ctrl_status       = '0;
    bus.ctrl_resp_ext     = '0;
  endtask

  task automatic wait_start(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus.ctrl_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic pwrup(input bit detailed);
    bit early = 1'b0;
    if (detailed) begin
      bus.ctrl_valid_status = 1'b1;
      bus.ctrl_status       = 7'h01;
      tick();
      bus.ctrl_valid_status = 1'b0;
      bus.ctrl_status       = '0;
    end
    for (int i = 1; i <= 80; i++) begin
      sclk_fall = 1'b1;
      tick();
      sclk_fall = 1'b0;
      if (bus.ctrl_start !== 1'b0) early = 1'b1;
      if (detailed && i == 79) chk("cs_after_79", {31'd0, cs}, 32'd1);
      if (i == 80) chk("cs_after_80", {31'd0, cs}, 32'd0);
      if (i < 80) begin
        tick();
        if (bus.ctrl_start !== 1'b0) early = 1'b1;
      end
    end
    if (detailed) chk("no_start_in_pwrup", {31'd0, early}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned n0 = 0, n8 = 0, n55 = 0, n41 = 0, n58 = 0, cyc = 0;
    logic [31:0] a41 = '1;
    logic [6:0]  rs;
    logic [31:0] rx;
    bit          stall_now;
    bit          bad;
    while (!(done || error) && cyc < 5000) begin
      if (bus.ctrl_start === 1'b1) begin
        rs = 7'h7F;
        rx = '0;
        case (bus.cmd)
          6'd0:  begin n0++;  rs = v.r0; end
          6'd8:  begin n8++;  rs = v.r8;  rx = v.e8; end
          6'd55: begin n55++; rs = v.r55; end
          6'd41: begin
            n41++;
            a41 = bus.cmd_arg;
            rs  = (n41 <= v.busy) ? 7'h01 : v.r41;
          end
          6'd58: begin n58++; rs = v.r58; rx = v.e58; end
          default: ;
        endcase
        stall_now = v.stall && (bus.cmd == 6'd0) && (rs == 7'h01);
        if (stall_now) bus.ctrl_available = 1'b0;
        respond(rs, rx);
        if (stall_now) begin
          bad = 1'b0;
          repeat (20) begin
            tick();
            if (bus.ctrl_start !== 1'b0 || bus.cmd !== 6'd8 || bus.cmd_arg !== 32'h1AA) bad = 1'b1;
          end
          chk("stall_hold", {31'd0, bad}, 32'd0);
          bus.ctrl_available = 1'b1;
          cyc += 20;
        end
        cyc += 2;
      end else begin
        tick();
        cyc++;
      end
    end
    chk($sformatf("v%0d_finished", idx), {31'd0, (cyc < 5000)}, 32'd1);
    chk($sformatf("v%0d_done", idx),     {31'd0, done},  {31'd0, v.x_done});
    chk($sformatf("v%0d_error", idx),    {31'd0, error}, {31'd0, v.x_err});
    chk($sformatf("v%0d_err_code", idx), {29'd0, err_code}, {29'd0, v.x_code});
    chk($sformatf("v%0d_sdhc", idx),     {31'd0, sdhc},  {31'd0, v.x_sdhc});
    chk($sformatf("v%0d_cs", idx),       {31'd0, cs},    v.x_done ? 32'd0 : 32'd1);
    chk($sformatf("v%0d_div", idx),      {24'd0, div_clk}, v.x_done ? 32'h00 : 32'hFF);
    chk($sformatf("v%0d_n_cmd0", idx),   n0,  v.n0);
    chk($sformatf("v%0d_n_cmd8", idx),   n8,  v.n8);
    chk($sformatf("v%0d_n_cmd55", idx),  n55, v.n55);
    chk($sformatf("v%0d_n_acmd41", idx), n41, v.n41);
    chk($sformatf("v%0d_n_cmd58", idx),  n58, v.n58);
    chk($sformatf("v%0d_acmd41_arg", idx), a41, v.arg41);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //          r0     r8     e8            r55    busy r41    r58    e58           st  d  e  code  hc n0 n8 n55 n41 n58 arg41
    vt[0] = '{7'h01, 7'h01, 32'h0000_01AA, 7'h01, 3,   7'h00, 7'h00, 32'hC0FF_8000, 0, 1, 0, 3'd0, 1, 1, 1, 4, 4, 1, 32'h4000_0000};
    vt[1] = '{7'h01, 7'h05, 32'h0000_0000, 7'h01, 1,   7'h00, 7'h00, 32'h0000_0000, 1, 1, 0, 3'd0, 0, 1, 1, 2, 2, 0, 32'h0000_0000};
    vt[2] = '{7'h01, 7'h01, 32'h0000_01AA, 7'h01, 0,   7'h00, 7'h00, 32'h80FF_8000, 0, 1, 0, 3'd0, 0, 1, 1, 1, 1, 1, 32'h4000_0000};
    vt[3] = '{7'h01, 7'h01, 32'h0000_01AA, 7'h01, 255, 7'h00, 7'h00, 32'h0000_0000, 0, 0, 1, 3'd4, 0, 1, 1, 4, 4, 0, 32'h4000_0000};
    vt[4] = '{7'h00, 7'h01, 32'h0000_01AA, 7'h01, 0,   7'h00, 7'h00, 32'h0000_0000, 0, 0, 1, 3'd1, 0, 8, 0, 0, 0, 0, 32'hFFFF_FFFF};
    vt[5] = '{7'h01, 7'h01, 32'h0000_01A5, 7'h01, 0,   7'h00, 7'h00, 32'h0000_0000, 0, 0, 1, 3'd2, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFFF};
    vt[6] = '{7'h01, 7'h01, 32'h0000_01AA, 7'h04, 0,   7'h00, 7'h00, 32'h0000_0000, 0, 0, 1, 3'd3, 0, 1, 1, 1, 0, 0, 32'hFFFF_FFFF};
    vt[7] = '{7'h01, 7'h01, 32'h0000_01AA, 7'h01, 0,   7'h05, 7'h00, 32'h0000_0000, 0, 0, 1, 3'd3, 0, 1, 1, 1, 1, 0, 32'h4000_0000};
    vt[8] = '{7'h01, 7'h01, 32'h0000_01AA, 7'h01, 0,   7'h00, 7'h01, 32'h0000_0000, 0, 0, 1, 3'd5, 0, 1, 1, 1, 1, 1, 32'h4000_0000};

    rst                   = 1'b1;
    init_req              = 1'b0;
    sclk_fall             = 1'b0;
    bus.ctrl_available    = 1'b1;
    bus.ctrl_valid_status = 1'b0;
    bus.ctrl_status       = '0;
    bus.ctrl_resp_ext     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ctrl_start", {31'd0, bus.ctrl_start}, 32'd0);
    chk("rst_cmd",        {26'd0, bus.cmd}, 32'd0);
    chk("rst_cmd_arg",    bus.cmd_arg, 32'd0);
    chk("rst_cs",         {31'd0, cs}, 32'd1);
    chk("rst_en_clk",     {31'd0, en_clk}, 32'd1);
    chk("rst_div",        {24'd0, div_clk}, 32'hFF);
    chk("rst_flags",      {28'd0, done, error, sdhc, 1'b0}, 32'd0);
    chk("rst_err_code",   {29'd0, err_code}, 32'd0);

    // Reset in the middle of the ACMD41 handshake.
    pwrup(1'b0);
    wait_start("mid_cmd0_start");
    respond(7'h01, 32'd0);
    wait_start("mid_cmd8_start");
    respond(7'h01, 32'h0000_01AA);
    wait_start("mid_cmd55_start");
    respond(7'h01, 32'd0);
    wait_start("mid_acmd41_start");
    chk("mid_acmd41_cmd", {26'd0, bus.cmd}, 32'd41);
    chk("mid_acmd41_arg", bus.cmd_arg, 32'h4000_0000);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_outputs",
        {bus.ctrl_start, bus.cmd, cs, en_clk, div_clk, done, error, err_code, sdhc},
        {1'b0, 6'd0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});
    chk("midrst_cmd_arg", bus.cmd_arg, 32'd0);
    rst = 1'b0;
    begin
      bit started = 1'b0;
      repeat (10) begin
        tick();
        if (bus.ctrl_start !== 1'b0 || cs !== 1'b1) started = 1'b1;
      end
      chk("midrst_stays_pwrup", {31'd0, started}, 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk($sformatf("v%0d_restart_state", i),
            {23'd0, cs, div_clk, done, error, err_code, sdhc},
            {23'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});
      end
      pwrup(i == 0);
      run_vec(i, vt[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_spi_init_seq.md
Name: sd_spi_init_seq

Overview:
Parametrised SPI-mode SD card initialisation sequencer that drives the SD command controller through power-up clocks, CMD0, CMD8, the CMD55/ACMD41 loop and CMD58. It detects v1, v2-SC and v2-HC cards, bounds every retry loop, and reports a coded error on failure. On success it switches the SPI clock divider from slow to fast and flags done. It sits between the top-level boot control and the SD command controller / SPI clock generator.

Parameters:
DUMMY_CLKS, 80, number of sclk falling edges with cs high before CMD0 (range 1..255)
DIV_W, 8, width of the clock divider output
SLOW_DIV, 8'hFF, divider value used during init (≤400 kHz)
FAST_DIV, 8'h00, divider value applied once in DONE
CMD0_RETRY, 8, CMD0 attempts before error
ACMD41_RETRY, 1000, ACMD41 attempts before error
RETRY_W, 10, retry counter width; must satisfy 2^RETRY_W > max(CMD0_RETRY, ACMD41_RETRY)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
init_req  in  1  one-cycle pulse; restarts the sequence, honoured only in DONE or ERROR
sclk_fall  in  1  one-cycle strobe per SPI clock falling edge
ctrl_available  in  1  command controller idle and able to accept ctrl_start
ctrl_valid_status  in  1  one-cycle strobe: response fields valid
ctrl_status  in  7  R1 response (bit0 idle, bit2 illegal command)
ctrl_resp_ext  in  32  trailing 32 bits of R3/R7 response, valid with ctrl_valid_status
ctrl_start  out  1  one-cycle command launch pulse
cmd  out  6  command index
cmd_arg  out  32  command argument
cs  out  1  SPI chip select, active low
en_clk  out  1  SPI clock enable
div_clk  out  DIV_W  SPI clock divider
done  out  1  card initialised
error  out  1  init failed
err_code  out  3  failure cause; 0 = none
sdhc  out  1  block-addressed card (OCR CCS)

Behaviour:
- Reset values: ctrl_start=0, cmd=0, cmd_arg=0, cs=1, en_clk=1, div_clk=SLOW_DIV, done=0, error=0, err_code=0, sdhc=0. State=PWRUP, all counters=0, v2 flag=0. A reset mid-sequence returns to these values on the next clk edge. No command is aborted gracefully.
- en_clk is constant 1.
- States: PWRUP, CMD0, CMD8, CMD55, ACMD41, CMD58, each command state with a paired _W (wait) state, then DONE and ERROR.
- PWRUP: cs=1. Count sclk_fall strobes. On the strobe that makes the count equal DUMMY_CLKS, go to CMD0 and set cs=0 in the same cycle.
- Command state X:
  - Drive cmd and cmd_arg.
  - When ctrl_available=1, pulse ctrl_start for exactly one cycle and enter X_W.
  - cmd and cmd_arg stay stable until the response is taken.
- X_W: waits for ctrl_valid_status. ctrl_valid_status is ignored in every other state.
- Command arguments: CMD0 (idx 0, arg 0); CMD8 (idx 8, arg 0x000001AA); CMD55 (idx 55, arg 0); ACMD41 (idx 41, arg 0x40000000 if v2 else 0); CMD58 (idx 58, arg 0).
- CMD0_W:
  - status 0x01 -> CMD8.
  - Otherwise increment the retry counter. On reaching CMD0_RETRY -> ERROR, err_code=1. Else -> CMD0.
- CMD8_W:
  - status bit2=1 -> v1 card, v2=0 -> CMD55.
  - status 0x01 and ext[11:0]=0x1AA -> v2=1 -> CMD55.
  - Else -> ERROR, err_code=2.
  - Clear the retry counter on exit.
- CMD55_W: status[6:1]=0 -> ACMD41. Else -> ERROR, err_code=3.
- ACMD41_W:
  - status 0x00 -> CMD58 if v2, else DONE with sdhc=0.
  - status 0x01 -> increment the retry counter. On reaching ACMD41_RETRY -> ERROR, err_code=4. Else -> CMD55.
  - Other values -> ERROR, err_code=3.
- CMD58_W: status 0x00 -> sdhc=ext[30], DONE. Else -> ERROR, err_code=5.
- DONE: done=1, cs=0, div_clk=FAST_DIV (applied on DONE entry).
- ERROR: error=1, cs=1, div_clk=SLOW_DIV.
- init_req in DONE/ERROR:
  - Clears done, error, err_code, sdhc, counters and v2.
  - Restores div_clk=SLOW_DIV and cs=1, then goes to PWRUP.
  - init_req in any other state is ignored.
- Counter widths: the dummy counter is 8 bits. The retry counter is RETRY_W bits and never wraps, because the limit check precedes any overflow.

Test Plan:
- PWRUP: DUMMY_CLKS=80, toggle sclk_fall -> cs stays 1 through 79 strobes and drops on the 80th; no ctrl_start before that.
- v2-HC path: responses CMD0=0x01, CMD8=0x01 with ext=0x000001AA, then ACMD41=0x01 ×3 then 0x00, CMD58=0x00 with ext=0xC0FF8000 -> ACMD41 arg 0x40000000, four CMD55/ACMD41 pairs, done=1, sdhc=1, div_clk=0x00.
- v1 path: CMD8 returns 0x05 -> ACMD41 arg 0, no CMD58 issued, done=1, sdhc=0.
- Timeout: ACMD41_RETRY=4, ACMD41 always 0x01 -> exactly 4 ACMD41 launches, then error=1, err_code=4, cs=1, div_clk=0xFF.
- CMD0 failure: CMD0 always 0x00 -> 8 CMD0 launches, err_code=1. Bad CMD8 echo 0x1A5 -> err_code=2.
- Handshake/restart: hold ctrl_available=0 for 20 cycles -> no ctrl_start and cmd held; a spurious ctrl_valid_status in PWRUP is ignored; rst asserted mid-ACMD41 -> reset values next cycle; init_req in DONE -> sequence reruns from PWRUP.
